// File: rtl/exec_writeback_stage_if.sv
// Bus bundle for the writeback stage: retire-side input, regfile write port and bypass lookup.
// The stage itself uses the slave modport; the surrounding pipeline uses master.
interface exec_writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_opcode;
  logic [4:0]        in_aluop;
  logic [REG_AW-1:0] in_rd;
  logic [DATA_W-1:0] in_result;
  logic              in_ovf;

  logic              wb_valid;
  logic              wb_ready;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic [REG_AW-1:0] fwd_raddr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output in_valid, in_opcode, in_aluop, in_rd, in_result, in_ovf,
    input  in_ready,
    input  wb_valid, wb_addr, wb_data,
    output wb_ready,
    output fwd_raddr,
    input  fwd_hit, fwd_data
  );

  modport slave (
    input  in_valid, in_opcode, in_aluop, in_rd, in_result, in_ovf,
    output in_ready,
    output wb_valid, wb_addr, wb_data,
    input  wb_ready,
    input  fwd_raddr,
    output fwd_hit, fwd_data
  );
endinterface

// File: rtl/exec_writeback_stage.sv
// Writeback stage: resolves overflow into $rstatus writes, drops $0 writes, and buffers
// up to two pending regfile writes with an in-order drain and a youngest-wins bypass lookup.
module exec_writeback_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int STATUS_REG = 30,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  exec_writeback_stage_if.slave bus,
  output logic [CNT_W-1:0]      ovf_count
);
  localparam logic [4:0]        OP_RTYPE    = 5'b00000;
  localparam logic [4:0]        OP_ADDI     = 5'b00101;
  localparam logic [4:0]        ALU_ADD     = 5'b00000;
  localparam logic [4:0]        ALU_SUB     = 5'b00001;
  localparam logic [REG_AW-1:0] STATUS_ADDR = REG_AW'(STATUS_REG);

  logic [REG_AW-1:0] addr_q [2];
  logic [DATA_W-1:0] data_q [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic              res_en;
  logic [REG_AW-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic              accept;
  logic              push;
  logic              pop;
  logic              young_ptr;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    res_en   = 1'b0;
    res_addr = '0;
    res_data = '0;
    if (bus.in_opcode == OP_RTYPE && bus.in_aluop == ALU_ADD && bus.in_ovf) begin
      res_en   = 1'b1;
      res_addr = STATUS_ADDR;
      res_data = DATA_W'(1);
    end else if (bus.in_opcode == OP_ADDI && bus.in_ovf) begin
      res_en   = 1'b1;
      res_addr = STATUS_ADDR;
      res_data = DATA_W'(2);
    end else if (bus.in_opcode == OP_RTYPE && bus.in_aluop == ALU_SUB && bus.in_ovf) begin
      res_en   = 1'b1;
      res_addr = STATUS_ADDR;
      res_data = DATA_W'(3);
    end else if ((bus.in_opcode == OP_RTYPE || bus.in_opcode == OP_ADDI) && !bus.in_ovf) begin
      res_en   = 1'b1;
      res_addr = bus.in_rd;
      res_data = bus.in_result;
    end
  end

  // in_ready depends only on stored occupancy, never on wb_ready.
  assign bus.in_ready = (count != 2'd2);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && res_en && (res_addr != '0);
  assign pop          = bus.wb_valid && bus.wb_ready;
  assign young_ptr    = ~rd_ptr;

  assign bus.wb_valid = (count != 2'd0);
  assign bus.wb_addr  = bus.wb_valid ? addr_q[rd_ptr] : '0;
  assign bus.wb_data  = bus.wb_valid ? data_q[rd_ptr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the two-entry store is reset along with the pointers; it is small, and it
      // keeps stale contents from ever reaching the bypass or write port after reset.
      addr_q    <= '{default: '0};
      data_q    <= '{default: '0};
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      ovf_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every update here sees pre-edge values.
      if (push) begin
        addr_q[wr_ptr] <= res_addr;
        data_q[wr_ptr] <= res_data;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (accept && bus.in_ovf && ovf_count != '1) ovf_count <= ovf_count + 1'b1;
    end
  end

  // The younger entry is checked last so its match overrides the older one.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    if (bus.fwd_raddr != '0) begin
      if (count != 2'd0 && addr_q[rd_ptr] == bus.fwd_raddr) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = data_q[rd_ptr];
      end
      if (count == 2'd2 && addr_q[young_ptr] == bus.fwd_raddr) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = data_q[young_ptr];
      end
    end
  end
endmodule

// File: tb/tb_exec_writeback_stage.sv
// Directed and randomized bench for exec_writeback_stage against a queue-based model.
// A narrow overflow counter is used so saturation is reachable in a short run.
module tb_exec_writeback_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [CW-1:0] ovf_count;

  exec_writeback_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

  exec_writeback_stage #(
    .DATA_W(DW), .REG_AW(AW), .STATUS_REG(30), .CNT_W(CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .ovf_count (ovf_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t         q[$];
  int unsigned m_cnt;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Resolution table written straight from the instruction rules.
  task automatic resolve(input logic [4:0] op, input logic [4:0] alu, input logic [AW-1:0] rd,
                         input logic [DW-1:0] res, input logic ovf,
                         output bit en, output logic [AW-1:0] a, output logic [DW-1:0] d);
    en = 0; a = '0; d = '0;
    if (ovf) begin
      if (op == 5'd0 && alu == 5'd0)      begin en = 1; a = 5'd30; d = 32'd1; end
      else if (op == 5'd5)                begin en = 1; a = 5'd30; d = 32'd2; end
      else if (op == 5'd0 && alu == 5'd1) begin en = 1; a = 5'd30; d = 32'd3; end
    end else if (op == 5'd0 || op == 5'd5) begin
      en = 1; a = rd; d = res;
    end
    if (a == '0) en = 0;
  endtask

  task automatic compare_all(input string ctx);
    bit            hit = 0;
    logic [DW-1:0] fd  = '0;
    for (int i = 0; i < q.size(); i++)
      if (bus.fwd_raddr != '0 && q[i].a == bus.fwd_raddr) begin hit = 1; fd = q[i].d; end
    check({ctx, ".in_ready"},  64'(bus.in_ready),  64'(q.size() < 2));
    check({ctx, ".wb_valid"},  64'(bus.wb_valid),  64'(q.size() != 0));
    check({ctx, ".wb_addr"},   64'(bus.wb_addr),   q.size() != 0 ? 64'(q[0].a) : 64'd0);
    check({ctx, ".wb_data"},   64'(bus.wb_data),   q.size() != 0 ? 64'(q[0].d) : 64'd0);
    check({ctx, ".fwd_hit"},   64'(bus.fwd_hit),   64'(hit));
    check({ctx, ".fwd_data"},  64'(bus.fwd_data),  64'(fd));
    check({ctx, ".ovf_count"}, 64'(ovf_count),     64'(m_cnt));
  endtask

  // One clock: predict accept/pop from pre-edge state, advance the model, then compare.
  task automatic step(input string ctx);
    bit            acc, pp, en;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    acc = bus.in_valid && (q.size() < 2);
    pp  = (q.size() != 0) && bus.wb_ready;
    resolve(bus.in_opcode, bus.in_aluop, bus.in_rd, bus.in_result, bus.in_ovf, en, a, d);
    @(posedge clock);
    if (pp) void'(q.pop_front());
    if (acc) begin
      if (bus.in_ovf && m_cnt < CNT_MAX) m_cnt++;
      if (en) q.push_back('{a: a, d: d});
    end
    #1;
    compare_all(ctx);
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] alu,
                       input logic [AW-1:0] rd, input logic [DW-1:0] res, input logic ovf);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_aluop  = alu;
    bus.in_rd     = rd;
    bus.in_result = res;
    bus.in_ovf    = ovf;
  endtask

  task automatic idle();
    drive(1'b0, 5'd31, 5'd0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    q.delete();
    m_cnt = 0;
    #1;
    check("reset.in_ready", 64'(bus.in_ready), 64'd1);
    check("reset.wb_valid", 64'(bus.wb_valid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    m_cnt         = 0;
    bus.wb_ready  = 1'b1;
    bus.fwd_raddr = '0;
    idle();
    #12;
    compare_all("reset_state");
    check("reset.wb_addr", 64'(bus.wb_addr), 64'd0);
    check("reset.fwd_hit", 64'(bus.fwd_hit), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // 1: addi $1 = 5
    drive(1'b1, 5'd5, 5'd0, 5'd1, 32'd5, 1'b0);
    step("t1.push");
    idle();
    check("t1.wb_valid", 64'(bus.wb_valid), 64'd1);
    check("t1.wb_addr",  64'(bus.wb_addr),  64'd1);
    check("t1.wb_data",  64'(bus.wb_data),  64'd5);
    step("t1.pop");
    check("t1.drained",  64'(bus.wb_valid), 64'd0);

    // 2: add overflow becomes ($30, 1)
    do_reset();
    bus.wb_ready = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd21, 32'h8000_0000, 1'b1);
    step("t2.push");
    idle();
    bus.fwd_raddr = 5'd21;
    #1;
    check("t2.no_rd_fwd", 64'(bus.fwd_hit),  64'd0);
    check("t2.wb_addr",   64'(bus.wb_addr),  64'd30);
    check("t2.wb_data",   64'(bus.wb_data),  64'd1);
    check("t2.ovf_count", 64'(ovf_count),    64'd1);
    bus.wb_ready = 1'b1;
    step("t2.pop");
    check("t2.drained",   64'(bus.wb_valid), 64'd0);

    // 3: addi overflow then sub overflow, in order
    do_reset();
    bus.wb_ready = 1'b0;
    drive(1'b1, 5'd5, 5'd0, 5'd23, 32'h7fff_ffff, 1'b1);
    step("t3.addi");
    drive(1'b1, 5'd0, 5'd1, 5'd25, 32'h0000_0001, 1'b1);
    step("t3.sub");
    idle();
    check("t3.first_addr", 64'(bus.wb_addr), 64'd30);
    check("t3.first_data", 64'(bus.wb_data), 64'd2);
    check("t3.ovf_count",  64'(ovf_count),   64'd2);
    bus.wb_ready = 1'b1;
    step("t3.pop1");
    check("t3.second_data", 64'(bus.wb_data), 64'd3);
    step("t3.pop2");

    // 4: write to $0 accepted and dropped
    drive(1'b1, 5'd0, 5'd2, 5'd0, 32'd7, 1'b0);
    step("t4.push");
    idle();
    check("t4.in_ready", 64'(bus.in_ready), 64'd1);
    check("t4.wb_valid", 64'(bus.wb_valid), 64'd0);

    // 5: fill, hold third, bypass, drain in order
    do_reset();
    bus.wb_ready = 1'b0;
    drive(1'b1, 5'd5, 5'd0, 5'd3, 32'd8, 1'b0); step("t5.p3");
    drive(1'b1, 5'd5, 5'd0, 5'd4, 32'd2, 1'b0); step("t5.p4");
    drive(1'b1, 5'd5, 5'd0, 5'd5, 32'd1, 1'b0); step("t5.hold");
    check("t5.full", 64'(bus.in_ready), 64'd0);
    bus.fwd_raddr = 5'd3;
    #1;
    check("t5.fwd_hit",  64'(bus.fwd_hit),  64'd1);
    check("t5.fwd_data", 64'(bus.fwd_data), 64'd8);
    bus.wb_ready = 1'b1;
    step("t5.pop3");
    check("t5.head4", 64'(bus.wb_addr), 64'd4);
    step("t5.pop4_push5");
    idle();
    check("t5.head5", 64'(bus.wb_addr), 64'd5);
    step("t5.pop5");
    check("t5.drained", 64'(bus.wb_valid), 64'd0);

    // 6: youngest bypass wins, then asynchronous reset mid-cycle
    drive(1'b1, 5'd0, 5'd0, 5'd9, 32'd0, 1'b1); step("t6.ovf");
    idle();                                      step("t6.ovf_pop");
    bus.wb_ready = 1'b0;
    drive(1'b1, 5'd5, 5'd0, 5'd3, 32'd8, 1'b0); step("t6.p8");
    drive(1'b1, 5'd5, 5'd0, 5'd3, 32'd9, 1'b0); step("t6.p9");
    idle();
    bus.fwd_raddr = 5'd3;
    #1;
    check("t6.fwd_young", 64'(bus.fwd_data), 64'd9);
    check("t6.cnt_before", 64'(ovf_count), 64'd1);
    #1;
    reset = 1'b1;
    q.delete();
    m_cnt = 0;
    #1;
    check("t6.rst_wb_valid",  64'(bus.wb_valid), 64'd0);
    check("t6.rst_fwd_hit",   64'(bus.fwd_hit),  64'd0);
    check("t6.rst_ovf_count", 64'(ovf_count),    64'd0);
    bus.fwd_raddr = 5'd0;
    @(negedge clock);
    reset = 1'b0;
    bus.wb_ready = 1'b1;
    step("t6.after_reset");

    // Saturation of the overflow counter
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd7, 32'd0, 1'b1);
      step("sat");
    end
    idle();
    check("sat.value", 64'(ovf_count), 64'(CNT_MAX));
    step("sat.drain");
    step("sat.drain2");

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [4:0] op, alu;
      logic       ovf;
      case ($urandom_range(0, 3))
        0, 1:    op = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd5;
        2:       op = 5'd0;
        default: op = 5'($urandom_range(0, 31));
      endcase
      alu = 5'($urandom_range(0, 3));
      ovf = (op == 5'd5 || (op == 5'd0 && alu < 5'd2)) ? ($urandom_range(0, 3) == 0) : 1'b0;
      drive(1'($urandom_range(0, 3) != 0), op, alu, 5'($urandom_range(0, 31)),
            $urandom, ovf);
      bus.wb_ready  = 1'($urandom_range(0, 2) != 0);
      bus.fwd_raddr = 5'($urandom_range(0, 31));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
